// File: rtl/voxel_ray_march_ctrl.sv
// Per-ray march sequencer: issues one step at a time into the voxel core, feeds each returned
// position/timer set back as the next step, and reports HIT, MISS or TIMEOUT downstream.
module voxel_ray_march_ctrl #(
  parameter int unsigned W         = 32,
  parameter int unsigned STEP_W    = 8,
  parameter int unsigned MAX_STEPS = 96,
  parameter int unsigned MAX_COORD = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  // Ray job
  input  logic              ray_valid_i,
  output logic              ray_ready_o,
  input  logic [4:0]        ray_ix_i,
  input  logic [4:0]        ray_iy_i,
  input  logic [4:0]        ray_iz_i,
  input  logic              ray_sx_i,
  input  logic              ray_sy_i,
  input  logic              ray_sz_i,
  input  logic [W-1:0]      ray_next_x_i,
  input  logic [W-1:0]      ray_next_y_i,
  input  logic [W-1:0]      ray_next_z_i,
  input  logic [W-1:0]      ray_inc_x_i,
  input  logic [W-1:0]      ray_inc_y_i,
  input  logic [W-1:0]      ray_inc_z_i,
  // Step issue to core
  output logic [4:0]        core_ix_o,
  output logic [4:0]        core_iy_o,
  output logic [4:0]        core_iz_o,
  output logic              core_sx_o,
  output logic              core_sy_o,
  output logic              core_sz_o,
  output logic [W-1:0]      core_next_x_o,
  output logic [W-1:0]      core_next_y_o,
  output logic [W-1:0]      core_next_z_o,
  output logic [W-1:0]      core_inc_x_o,
  output logic [W-1:0]      core_inc_y_o,
  output logic [W-1:0]      core_inc_z_o,
  output logic              core_step_valid_o,
  // Step return from core
  input  logic [4:0]        cr_ix_i,
  input  logic [4:0]        cr_iy_i,
  input  logic [4:0]        cr_iz_i,
  input  logic [W-1:0]      cr_next_x_i,
  input  logic [W-1:0]      cr_next_y_i,
  input  logic [W-1:0]      cr_next_z_i,
  input  logic [2:0]        cr_face_id_i,
  input  logic              cr_oob_i,
  input  logic              cr_occupied_i,
  input  logic              cr_valid_i,
  // Result
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [1:0]        res_status_o,
  output logic [4:0]        res_ix_o,
  output logic [4:0]        res_iy_o,
  output logic [4:0]        res_iz_o,
  output logic [2:0]        res_face_id_o,
  output logic [STEP_W-1:0] res_steps_o
);

  localparam logic [1:0]        StatMiss    = 2'b00;
  localparam logic [1:0]        StatHit     = 2'b01;
  localparam logic [1:0]        StatTimeout = 2'b10;
  localparam logic [4:0]        CoordMax    = 5'(MAX_COORD);
  localparam logic [STEP_W-1:0] StepMax     = STEP_W'(MAX_STEPS);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e                  state_q, state_d;
  logic                    ray_ready_q, ray_ready_d;
  logic [2:0][4:0]         pos_q, pos_d;
  logic [2:0]              sign_q, sign_d;
  logic [2:0][W-1:0]       tmr_q, tmr_d;
  logic [2:0][W-1:0]       inc_q, inc_d;
  logic [STEP_W-1:0]       steps_q, steps_d;
  logic [2:0]              prev_face_q, prev_face_d;
  logic [1:0]              res_status_q, res_status_d;
  logic [2:0][4:0]         res_pos_q, res_pos_d;
  logic [2:0]              res_face_q, res_face_d;
  logic [STEP_W-1:0]       res_steps_q, res_steps_d;
  logic [2:0][4:0]         cr_pos;
  logic                    wrapped;

  // The core wraps a coordinate that steps off the grid; an axis that moved from its boundary
  // in the direction of travel means the ray has left the volume.
  function automatic logic axis_wrap(input logic [4:0] issued, input logic [4:0] ret,
                                     input logic sign);
    return (ret != issued) &&
           ((!sign && issued == CoordMax) || (sign && issued == 5'd0));
  endfunction

  assign cr_pos  = {cr_iz_i, cr_iy_i, cr_ix_i};
  assign wrapped = axis_wrap(pos_q[0], cr_pos[0], sign_q[0]) |
                   axis_wrap(pos_q[1], cr_pos[1], sign_q[1]) |
                   axis_wrap(pos_q[2], cr_pos[2], sign_q[2]);

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    sign_d       = sign_q;
    tmr_d        = tmr_q;
    inc_d        = inc_q;
    steps_d      = steps_q;
    prev_face_d  = prev_face_q;
    res_status_d = res_status_q;
    res_pos_d    = res_pos_q;
    res_face_d   = res_face_q;
    res_steps_d  = res_steps_q;
    unique case (state_q)
      StIdle: begin
        if (ray_valid_i && ray_ready_q) begin
          pos_d       = {ray_iz_i, ray_iy_i, ray_ix_i};
          sign_d      = {ray_sz_i, ray_sy_i, ray_sx_i};
          tmr_d       = {ray_next_z_i, ray_next_y_i, ray_next_x_i};
          inc_d       = {ray_inc_z_i, ray_inc_y_i, ray_inc_x_i};
          steps_d     = '0;
          prev_face_d = '0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        steps_d = steps_q + 1'b1;
        state_d = StWait;
      end
      StWait: begin
        if (cr_valid_i) begin
          state_d     = StDone;
          res_pos_d   = pos_q;
          res_face_d  = prev_face_q;
          res_steps_d = steps_q;
          if (cr_occupied_i) begin
            res_status_d = StatHit;
          end else if (cr_oob_i || wrapped) begin
            res_status_d = StatMiss;
          end else if (steps_q == StepMax) begin
            res_status_d = StatTimeout;
          end else begin
            pos_d       = cr_pos;
            tmr_d       = {cr_next_z_i, cr_next_y_i, cr_next_x_i};
            prev_face_d = cr_face_id_i;
            state_d     = StIssue;
          end
        end
      end
      StDone: begin
        if (res_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered so that ready stays low through reset and rises one cycle after release.
  assign ray_ready_d = (state_d == StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ray_ready_q  <= 1'b0;
      pos_q        <= '0;
      sign_q       <= '0;
      tmr_q        <= '0;
      inc_q        <= '0;
      steps_q      <= '0;
      prev_face_q  <= '0;
      res_status_q <= '0;
      res_pos_q    <= '0;
      res_face_q   <= '0;
      res_steps_q  <= '0;
    end else begin
      state_q      <= state_d;
      ray_ready_q  <= ray_ready_d;
      pos_q        <= pos_d;
      sign_q       <= sign_d;
      tmr_q        <= tmr_d;
      inc_q        <= inc_d;
      steps_q      <= steps_d;
      prev_face_q  <= prev_face_d;
      res_status_q <= res_status_d;
      res_pos_q    <= res_pos_d;
      res_face_q   <= res_face_d;
      res_steps_q  <= res_steps_d;
    end
  end

  assign ray_ready_o       = ray_ready_q;
  assign core_step_valid_o = (state_q == StIssue);
  assign core_ix_o         = pos_q[0];
  assign core_iy_o         = pos_q[1];
  assign core_iz_o         = pos_q[2];
  assign core_sx_o         = sign_q[0];
  assign core_sy_o         = sign_q[1];
  assign core_sz_o         = sign_q[2];
  assign core_next_x_o     = tmr_q[0];
  assign core_next_y_o     = tmr_q[1];
  assign core_next_z_o     = tmr_q[2];
  assign core_inc_x_o      = inc_q[0];
  assign core_inc_y_o      = inc_q[1];
  assign core_inc_z_o      = inc_q[2];

  assign res_valid_o       = (state_q == StDone);
  assign res_status_o      = res_status_q;
  assign res_ix_o          = res_pos_q[0];
  assign res_iy_o          = res_pos_q[1];
  assign res_iz_o          = res_pos_q[2];
  assign res_face_id_o     = res_face_q;
  assign res_steps_o       = res_steps_q;

endmodule
